mult_div_unit: RTL and testbench



---
 rtl/md_pkg.sv | 27 ++
 rtl/md_cond_negate.sv | 13 +
 rtl/mult_div_unit.sv | 173 +++++++++++++++++
 tb/tb_mult_div_unit.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/md_pkg.sv
// Shared encodings for the iterative multiply/divide unit: operation codes,
// FSM states and the iteration-counter sizing helper.
package md_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } md_state_e;

  localparam int MD_OP_W = 3;

  // Counter must hold the value WIDTH itself (it counts WIDTH..1).
  function automatic int md_cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/md_cond_negate.sv
// Combinational conditional two's-complement negator, used both to take
// operand magnitudes and to restore result signs.
module md_cond_negate #(
  parameter int W = 32
) (
  input  logic         en_i,
  input  logic [W-1:0] val_i,
  output logic [W-1:0] val_o
);

  assign val_o = en_i ? (~val_i + W'(1)) : val_i;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MIPS multiply/divide unit with architectural HI/LO registers.
// One bit per cycle for WIDTH cycles, then one sign/special-case fix-up cycle.
module mult_div_unit
  import md_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start_in,
  input  logic [MD_OP_W-1:0] op_in,
  input  logic [WIDTH-1:0]   a_in,
  input  logic [WIDTH-1:0]   b_in,
  output logic               busy_out,
  output logic               done_out,
  output logic [WIDTH-1:0]   hi_out,
  output logic [WIDTH-1:0]   lo_out
);

  localparam int CNT_W = md_cnt_width(WIDTH);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             is_div_q, is_div_d;
  logic             neg_res_q, neg_res_d;
  logic             neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0] work_hi_q, work_hi_d;
  logic [WIDTH-1:0] work_lo_q, work_lo_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [WIDTH-1:0] a_raw_q, a_raw_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;

  // Operand magnitudes for signed ops
  logic             op_signed, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;

  assign op_signed = (op_in == MD_MULT) || (op_in == MD_DIV);
  assign a_neg     = op_signed & a_in[WIDTH-1];
  assign b_neg     = op_signed & b_in[WIDTH-1];

  md_cond_negate #(.W(WIDTH)) u_neg_a (.en_i(a_neg), .val_i(a_in), .val_o(a_mag));
  md_cond_negate #(.W(WIDTH)) u_neg_b (.en_i(b_neg), .val_i(b_in), .val_o(b_mag));

  // Shift-add step: work_hi accumulates, work_lo holds the multiplier and
  // fills with product low bits from the top.
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi_next, mul_lo_next;

  assign mul_sum     = {1'b0, work_hi_q} + (work_lo_q[0] ? {1'b0, opnd_q} : '0);
  assign mul_hi_next = mul_sum[WIDTH:1];
  assign mul_lo_next = {mul_sum[0], work_lo_q[WIDTH-1:1]};

  // Restoring-division step: work_hi is the partial remainder, work_lo shifts
  // dividend bits out of the top and quotient bits in at the bottom.
  logic [WIDTH:0]   div_shift, div_trial;
  logic             div_ok;
  logic [WIDTH-1:0] div_hi_next, div_lo_next;

  assign div_shift   = {work_hi_q, work_lo_q[WIDTH-1]};
  assign div_trial   = div_shift - {1'b0, opnd_q};
  assign div_ok      = ~div_trial[WIDTH];
  assign div_hi_next = div_ok ? div_trial[WIDTH-1:0] : div_shift[WIDTH-1:0];
  assign div_lo_next = {work_lo_q[WIDTH-2:0], div_ok};

  // Sign fix-up of finished magnitudes
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  md_cond_negate #(.W(2*WIDTH)) u_neg_prod (
    .en_i (neg_res_q),
    .val_i({work_hi_q, work_lo_q}),
    .val_o(prod_fix)
  );
  md_cond_negate #(.W(WIDTH)) u_neg_quo (.en_i(neg_res_q), .val_i(work_lo_q), .val_o(quo_fix));
  md_cond_negate #(.W(WIDTH)) u_neg_rem (.en_i(neg_rem_q), .val_i(work_hi_q), .val_o(rem_fix));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    work_hi_d = work_hi_q;
    work_lo_d = work_lo_q;
    opnd_d    = opnd_q;
    a_raw_d   = a_raw_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_in) begin
          case (op_in)
            MD_MTHI: hi_d = a_in;
            MD_MTLO: lo_d = a_in;
            MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
              state_d   = RUN;
              cnt_d     = CNT_W'(WIDTH);
              is_div_d  = (op_in == MD_DIV) || (op_in == MD_DIVU);
              neg_res_d = a_neg ^ b_neg;
              neg_rem_d = a_neg;
              work_hi_d = '0;
              work_lo_d = a_mag;
              opnd_d    = b_mag;
              a_raw_d   = a_in;
            end
            default: ;
          endcase
        end
      end
      RUN: begin
        work_hi_d = is_div_q ? div_hi_next : mul_hi_next;
        work_lo_d = is_div_q ? div_lo_next : mul_lo_next;
        cnt_d     = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = FIX;
      end
      FIX: begin
        state_d = IDLE;
        done_d  = 1'b1;
        if (!is_div_q) begin
          {hi_d, lo_d} = prod_fix;
        end else if (opnd_q == '0) begin
          // Divide by zero: dividend passes through unmodified
          hi_d = a_raw_q;
          lo_d = '1;
        end else begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      work_hi_q <= '0;
      work_lo_q <= '0;
      opnd_q    <= '0;
      a_raw_q   <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      work_hi_q <= work_hi_d;
      work_lo_q <= work_lo_d;
      opnd_q    <= opnd_d;
      a_raw_q   <= a_raw_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

  assign busy_out = (state_q != IDLE);
  assign done_out = done_q;
  assign hi_out   = hi_q;
  assign lo_out   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed vector table, handshake
// sequences and randomized operations against an arithmetic reference model.
module tb_mult_div_unit;

  localparam int W = 32;
  localparam int LAT = W + 1;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         start_in = 1'b0;
  logic [2:0]   op_in = 3'd0;
  logic [W-1:0] a_in = '0;
  logic [W-1:0] b_in = '0;
  logic         busy_out, done_out;
  logic [W-1:0] hi_out, lo_out;

  int n_checks = 0;
  int n_fail = 0;

  mult_div_unit #(.WIDTH(W)) dut (
    .clock   (clock),
    .reset   (reset),
    .start_in(start_in),
    .op_in   (op_in),
    .a_in    (a_in),
    .b_in    (b_in),
    .busy_out(busy_out),
    .done_out(done_out),
    .hi_out  (hi_out),
    .lo_out  (lo_out)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain wide arithmetic with SV division semantics
  task automatic model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] hi, output logic [W-1:0] lo);
    logic [63:0] p;
    longint sa, sb, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    hi = '0;
    lo = '0;
    case (op)
      3'd0: begin p = 64'(sa * sb); hi = p[63:32]; lo = p[31:0]; end
      3'd1: begin p = {32'd0, a} * {32'd0, b}; hi = p[63:32]; lo = p[31:0]; end
      3'd2, 3'd3: begin
        if (b == 0) begin
          hi = a; lo = '1;
        end else if (op == 3'd2) begin
          q = sa / sb; r = sa % sb;
          p = 64'(q); lo = p[31:0];
          p = 64'(r); hi = p[31:0];
        end else begin
          lo = a / b; hi = a % b;
        end
      end
      default: ;
    endcase
  endtask

  // Caller is at a negedge; issues now, returns at the negedge of the done cycle.
  task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [W-1:0] hi, output logic [W-1:0] lo,
                        output int lat, output int busy_cnt);
    start_in = 1'b1; op_in = op; a_in = a; b_in = b;
    @(negedge clock);
    start_in = 1'b0; a_in = ~a; b_in = ~b;
    lat = 0; busy_cnt = 0;
    while (!done_out && lat < 100) begin
      if (busy_out) busy_cnt++;
      @(negedge clock);
      lat++;
    end
    hi = hi_out; lo = lo_out;
  endtask

  logic [W-1:0] g_hi, g_lo, e_hi, e_lo;
  int lat, bcnt, dcount;

  initial begin
    vecs[0] = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[1] = '{3'd0, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[2] = '{3'd2, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3] = '{3'd3, 32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003};
    vecs[4] = '{3'd2, 32'h12345678, 32'h00000000, 32'h12345678, 32'hFFFFFFFF};
    vecs[5] = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[6] = '{3'd2, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    vecs[7] = '{3'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[8] = '{3'd3, 32'h80000001, 32'h00000000, 32'h80000001, 32'hFFFFFFFF};
    vecs[9] = '{3'd2, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF};

    repeat (3) @(negedge clock);
    reset = 1'b0;
    check("reset_busy", 64'(busy_out), 64'd0);
    check("reset_done", 64'(done_out), 64'd0);
    check("reset_hi", 64'(hi_out), 64'd0);
    check("reset_lo", 64'(lo_out), 64'd0);

    // Directed vectors, each issued in the previous done cycle
    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, g_hi, g_lo, lat, bcnt);
      $display("vec %0d op=%0d a=%h b=%h -> hi=%h lo=%h lat=%0d", i, vecs[i].op,
               vecs[i].a, vecs[i].b, g_hi, g_lo, lat);
      check($sformatf("vec%0d_lat", i), 64'(lat), 64'(LAT));
      check($sformatf("vec%0d_busy", i), 64'(bcnt), 64'(LAT));
      check($sformatf("vec%0d_hi", i), 64'(g_hi), 64'(vecs[i].hi));
      check($sformatf("vec%0d_lo", i), 64'(g_lo), 64'(vecs[i].lo));
    end

    // start_in pulsed mid-RUN must be ignored
    @(negedge clock);
    start_in = 1'b1; op_in = 3'd1; a_in = 32'd1000; b_in = 32'd3000;
    @(negedge clock);
    start_in = 1'b0;
    repeat (5) @(negedge clock);
    start_in = 1'b1; op_in = 3'd3; a_in = 32'd99; b_in = 32'd5;
    @(negedge clock);
    start_in = 1'b0;
    lat = 6;
    while (!done_out && lat < 100) begin @(negedge clock); lat++; end
    $display("midrun ignore: hi=%h lo=%h lat=%0d", hi_out, lo_out, lat);
    check("midrun_lat", 64'(lat), 64'(LAT));
    check("midrun_hi", 64'(hi_out), 64'd0);
    check("midrun_lo", 64'(lo_out), 64'd3000000);
    @(negedge clock);
    check("midrun_no_2nd_start", 64'(busy_out), 64'd0);

    // MTHI / MTLO: immediate, no busy, no done
    start_in = 1'b1; op_in = 3'd4; a_in = 32'hA5A5A5A5;
    @(negedge clock);
    start_in = 1'b0;
    $display("mthi: hi=%h busy=%b done=%b", hi_out, busy_out, done_out);
    check("mthi_hi", 64'(hi_out), 64'hA5A5A5A5);
    check("mthi_lo_kept", 64'(lo_out), 64'd3000000);
    check("mthi_busy", 64'(busy_out), 64'd0);
    check("mthi_done", 64'(done_out), 64'd0);
    start_in = 1'b1; op_in = 3'd5; a_in = 32'h5A5A0001;
    @(negedge clock);
    start_in = 1'b0;
    $display("mtlo: lo=%h", lo_out);
    check("mtlo_lo", 64'(lo_out), 64'h5A5A0001);
    check("mtlo_hi_kept", 64'(hi_out), 64'hA5A5A5A5);
    // Reserved op does nothing
    start_in = 1'b1; op_in = 3'd6; a_in = 32'h1;
    @(negedge clock);
    start_in = 1'b0;
    check("rsvd_busy", 64'(busy_out), 64'd0);
    check("rsvd_hi", 64'(hi_out), 64'hA5A5A5A5);

    // Reset during a DIVU abandons it
    start_in = 1'b1; op_in = 3'd3; a_in = 32'd12345; b_in = 32'd7;
    @(negedge clock);
    start_in = 1'b0;
    repeat (10) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    $display("reset mid-DIVU: busy=%b hi=%h lo=%h", busy_out, hi_out, lo_out);
    check("rst_run_busy", 64'(busy_out), 64'd0);
    check("rst_run_hi", 64'(hi_out), 64'd0);
    check("rst_run_lo", 64'(lo_out), 64'd0);
    dcount = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (done_out) dcount++;
    end
    check("rst_run_no_done", 64'(dcount), 64'd0);

    // Randomized back-to-back arithmetic ops
    for (int i = 0; i < 150; i++) begin
      logic [2:0] op;
      logic [W-1:0] a, b;
      op = 3'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = '0;
        1: b = 32'hFFFFFFFF;
        2: a = 32'h80000000;
        3: b = 32'($urandom_range(1, 20));
        default: ;
      endcase
      model(op, a, b, e_hi, e_lo);
      run_op(op, a, b, g_hi, g_lo, lat, bcnt);
      $display("rnd %0d op=%0d a=%h b=%h -> hi=%h lo=%h exp hi=%h lo=%h", i, op, a, b,
               g_hi, g_lo, e_hi, e_lo);
      check("rnd_lat", 64'(lat), 64'(LAT));
      check("rnd_hi", 64'(g_hi), 64'(e_hi));
      check("rnd_lo", 64'(g_lo), 64'(e_lo));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
